// File: rtl/minilab1_mac_fifo.sv
// minilab1_mac_fifo: loads an 8x8 byte matrix A and 8-byte vector B from a
// small ROM into byte FIFOs, then runs eight parallel MAC lanes to form
// C[i] = sum_j A[i][j]*B[j]. Results are held until the next reset.
// Optional: define MINILAB1_LED_STATUS_EN to drive FSM status onto LEDR.

// 8-deep x 8-bit FIFO, synchronous write, registered read.
module minilab1_fifo (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wren,
   input  logic       rden,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);
   logic [7:0] mem [0:7];
   logic [2:0] wptr, rptr;
   logic [3:0] cnt;
   logic       do_wr, do_rd;

   assign full  = (cnt == 4'd8);
   assign empty = (cnt == 4'd0);
   // writes while full and reads while empty are dropped
   assign do_wr = wren && !full;
   assign do_rd = rden && !empty;

   // storage array, no reset needed
   always_ff @(posedge clk)
      if (do_wr) mem[wptr] <= wdata;

   // pointers, occupancy and registered read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt   <= '0;
         rdata <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 3'd1;
         if (do_rd) begin
            rptr  <= rptr + 3'd1;
            rdata <= mem[rptr];
         end
         cnt <= cnt + {3'd0, do_wr} - {3'd0, do_rd};
      end
   end
endmodule

// One MAC lane: 8x8 unsigned product, zero-extended into a 24-bit accumulator.
module minilab1_mac_lane (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [23:0] acc
);
   logic [15:0] prod;
   assign prod = {8'd0, a} * {8'd0, b};

   // accumulate when the popped operands are valid
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)  acc <= '0;
      else if (en) acc <= acc + {8'd0, prod};
endmodule

module minilab1_mac_fifo (
   input  logic       CLOCK_50,
   input  logic       CLOCK2_50,
   input  logic       CLOCK3_50,
   input  logic       CLOCK4_50,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [9:0] LEDR
);
   localparam int NUM_LANES = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0, READ = 3'd1, FILLA = 3'd2, FILLB = 3'd3,
      MAC  = 3'd4, DRAIN = 3'd5, DONE = 3'd6
   } state_t;

   logic                 rst_n;
   state_t               state, next_state;
   logic [7:0]           datain;
   logic [0:7][7:0]      readdata_byte;
   logic [0:7][7:0]      rom_word;
   logic [NUM_LANES-1:0] wrenA, fullA, emptyA;
   logic                 wrenB, fullB, emptyB, allFull;
   logic [0:7][23:0]     cout_reg;
   logic [NUM_LANES-1:0][7:0] a_q;
   logic [7:0]           b_q;
   logic [2:0]           row, mac_cnt;
   logic [3:0]           col, row_p1;
   logic                 tgt_b, rd_valid, rom_rd, pop;
   logic [1:0]           vld_pipe;
   logic                 unused_ok;

   assign rst_n   = KEY[0];
   assign allFull = (&fullA) & fullB;
   assign row_p1  = {1'b0, row} + 4'd1;
   assign unused_ok = &{1'b0, CLOCK2_50, CLOCK3_50, CLOCK4_50, SW, KEY[3:1], allFull};

   // ROM: words 0..7 are A rows (16*(r+1)+j), word 8 is B (j); byte 0 is MSB
   always_comb begin
      rom_word = '0;
      for (int j = 0; j < 8; j++)
         rom_word[j] = tgt_b ? 8'(j) : {row_p1, 4'(j)};
   end

   // state register plus row/column/MAC counters
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         row     <= '0;
         col     <= '0;
         mac_cnt <= '0;
         tgt_b   <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            IDLE:  tgt_b <= 1'b1;
            READ:  col   <= '0;
            FILLB: if (col != 4'd8) col <= col + 4'd1;
                   else begin
                      tgt_b <= 1'b0;
                      row   <= '0;
                   end
            FILLA: if (col != 4'd8) col <= col + 4'd1;
                   else if (row != 3'd7) row <= row + 3'd1;
            MAC:   mac_cnt <= mac_cnt + 3'd1;
            default: ;
         endcase
      end
   end

   // one-cycle ROM read; the valid flag drops once READ is left
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         readdata_byte <= '0;
         rd_valid      <= 1'b0;
      end else if (rom_rd) begin
         readdata_byte <= rom_word;
         rd_valid      <= 1'b1;
      end else if (state != READ) begin
         rd_valid      <= 1'b0;
      end
   end

   // pop valid pipeline: [0] = FIFO read data valid, [1] = accumulated one cycle later
   always_ff @(posedge CLOCK_50 or negedge rst_n)
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= {vld_pipe[0], pop};

   // next-state and FIFO write/pop strobes; a FILL's 9th cycle only hands back to READ
   always_comb begin
      next_state = state;
      datain     = '0;
      wrenA      = '0;
      wrenB      = 1'b0;
      pop        = 1'b0;
      rom_rd     = 1'b0;
      case (state)
         IDLE:  next_state = READ;
         READ:  if (!rd_valid) rom_rd = 1'b1;
                else next_state = tgt_b ? FILLB : FILLA;
         FILLB: if (col == 4'd8) next_state = READ;
                else begin
                   wrenB  = 1'b1;
                   datain = readdata_byte[col[2:0]];
                end
         FILLA: if (col == 4'd8) next_state = (row == 3'd7) ? MAC : READ;
                else begin
                   wrenA[row] = 1'b1;
                   datain     = readdata_byte[col[2:0]];
                end
         MAC: begin
            pop = 1'b1;
            if (mac_cnt == 3'd7) next_state = DRAIN;
         end
         DRAIN: if (vld_pipe == 2'b00 && emptyB) next_state = DONE;
         DONE:  ;
         default: next_state = IDLE;
      endcase
   end

   minilab1_fifo u_fifo_b (
      .clk(CLOCK_50), .rst_n(rst_n), .wren(wrenB), .rden(pop), .wdata(datain),
      .rdata(b_q), .full(fullB), .empty(emptyB)
   );

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      minilab1_fifo u_fifo_a (
         .clk(CLOCK_50), .rst_n(rst_n), .wren(wrenA[i]), .rden(pop), .wdata(datain),
         .rdata(a_q[i]), .full(fullA[i]), .empty(emptyA[i])
      );
      minilab1_mac_lane u_mac (
         .clk(CLOCK_50), .rst_n(rst_n), .en(vld_pipe[0]), .a(a_q[i]), .b(b_q),
         .acc(cout_reg[i])
      );
   end

`ifdef MINILAB1_LED_STATUS_EN
   assign LEDR = {5'd0, state == DONE, allFull, state};
`else
   assign LEDR = '0;
`endif
endmodule

// File: tb/tb_minilab1_mac_fifo.sv
// Bench for minilab1_mac_fifo: reset values, fill sequences, final results,
// flag ordering, LED status and randomly timed mid-run resets.
module tb_minilab1_mac_fifo;
   logic       CLOCK_50 = 1'b0;
   logic       CLOCK2_50 = 1'b0, CLOCK3_50 = 1'b0, CLOCK4_50 = 1'b0;
   logic [3:0] KEY = 4'b1110;
   logic [9:0] SW = '0;
   logic [9:0] LEDR;
   int n_cmp = 0;
   int n_bad = 0;

   minilab1_mac_fifo dut (
      .CLOCK_50(CLOCK_50), .CLOCK2_50(CLOCK2_50), .CLOCK3_50(CLOCK3_50),
      .CLOCK4_50(CLOCK4_50), .KEY(KEY), .SW(SW), .LEDR(LEDR)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // reference model straight from the matrix definition
   function automatic int a_elem(int i, int j); return 16 * (i + 1) + j; endfunction
   function automatic int b_elem(int j); return j; endfunction
   function automatic int exp_c(int i);
      int s = 0;
      for (int j = 0; j < 8; j++) s += a_elem(i, j) * b_elem(j);
      return s;
   endfunction

   // READ never writes; LEDR stays 0 in the default build
   always @(negedge CLOCK_50) begin
      if (KEY[0] && dut.state == 3'd1) begin
         n_cmp++;
         if (dut.wrenA !== 8'd0 || dut.wrenB !== 1'b0) begin
            n_bad++;
            $display("FAIL read_no_write: wrenA=%h wrenB=%b want 0", dut.wrenA, dut.wrenB);
         end
      end
`ifndef MINILAB1_LED_STATUS_EN
      n_cmp++;
      if (LEDR !== 10'd0) begin
         n_bad++;
         $display("FAIL ledr_zero: got %h want 0", LEDR);
      end
`endif
   end

   task automatic do_reset();
      KEY[0] = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      KEY[0] = 1'b1;
   endtask

   task automatic wait_state(input int s, input int budget, output bit ok, output int cyc);
      ok = 0; cyc = 0;
      while (cyc < budget) begin
         if (dut.state == 3'(s)) begin ok = 1; return; end
         @(negedge CLOCK_50);
         cyc++;
      end
   endtask

   task automatic test_reset();
      KEY[0] = 1'b0;
      #1;
      n_cmp++;
      if (dut.state !== 3'd0 || dut.wrenA !== 8'd0 || dut.wrenB !== 1'b0 || dut.datain !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_ctrl: state=%0d wrenA=%h wrenB=%b datain=%0d want 0", dut.state, dut.wrenA, dut.wrenB, dut.datain);
      end
      @(negedge CLOCK_50);
      n_cmp++;
      if (dut.emptyA !== 8'hFF || dut.fullA !== 8'h00 || dut.allFull !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_flags: emptyA=%h fullA=%h allFull=%b want ff/00/0", dut.emptyA, dut.fullA, dut.allFull);
      end
      n_cmp++;
      if (dut.cout_reg !== '0 || dut.readdata_byte !== '0 || LEDR !== 10'd0) begin
         n_bad++;
         $display("FAIL reset_data: cout nonzero=%b rdbyte=%h ledr=%h want 0", |dut.cout_reg, dut.readdata_byte, LEDR);
      end
      KEY[0] = 1'b1;
   endtask

   task automatic test_fillb();
      bit ok; int cyc;
      do_reset();
      wait_state(3, 50, ok, cyc);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL fillb_reach: timeout state=%0d want 3", dut.state); return; end
      for (int j = 0; j < 8; j++) begin
         n_cmp++;
         if (dut.wrenB !== 1'b1 || dut.datain !== 8'(b_elem(j)) || dut.readdata_byte[j] !== 8'(b_elem(j))) begin
            n_bad++;
            $display("FAIL fillb_j%0d: wrenB=%b datain=%0d want 1/%0d", j, dut.wrenB, dut.datain, b_elem(j));
         end
         @(negedge CLOCK_50);
      end
      n_cmp++;
      if (dut.wrenB !== 1'b0) begin n_bad++; $display("FAIL fillb_end: wrenB=%b want 0", dut.wrenB); end
      @(negedge CLOCK_50);
   endtask

   task automatic test_filla();
      bit ok; int cyc;
      for (int i = 0; i < 8; i++) begin
         wait_state(2, 50, ok, cyc);
         n_cmp++;
         if (!ok) begin n_bad++; $display("FAIL filla_reach row %0d: timeout", i); return; end
         for (int j = 0; j < 8; j++) begin
            n_cmp++;
            if (dut.wrenA !== 8'(1 << i) || dut.wrenB !== 1'b0 || dut.datain !== 8'(a_elem(i, j))) begin
               n_bad++;
               $display("FAIL filla_r%0d_j%0d: wrenA=%h datain=%0d want %h/%0d", i, j, dut.wrenA, dut.datain, 8'(1 << i), a_elem(i, j));
            end
            if (j == 7) begin
               n_cmp++;
               if (dut.allFull !== 1'b0) begin n_bad++; $display("FAIL allfull_early: row %0d got 1 want 0", i); end
            end
            @(negedge CLOCK_50);
         end
         n_cmp++;
         if (dut.wrenA !== 8'd0 || dut.allFull !== (i == 7)) begin
            n_bad++;
            $display("FAIL filla_end r%0d: wrenA=%h allFull=%b want 0/%0d", i, dut.wrenA, dut.allFull, i == 7);
         end
         @(negedge CLOCK_50);
      end
   endtask

   task automatic check_results(input string tag);
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (dut.cout_reg[i] !== 24'(exp_c(i))) begin
            n_bad++;
            $display("FAIL %s_c%0d: got %0d want %0d", tag, i, dut.cout_reg[i], exp_c(i));
         end
      end
   endtask

   task automatic test_results();
      bit ok; int cyc;
      do_reset();
      wait_state(6, 200, ok, cyc);
      n_cmp++;
      if (!ok || cyc >= 150) begin
         n_bad++;
         $display("FAIL done_latency: got %0d cycles (reached=%0d) want <150", cyc, ok);
      end
      check_results("done");
      n_cmp++;
`ifdef MINILAB1_LED_STATUS_EN
      if (LEDR[4] !== 1'b1 || LEDR[2:0] !== 3'd6 || LEDR[9:5] !== 5'd0) begin
`else
      if (LEDR !== 10'd0) begin
`endif
         n_bad++;
         $display("FAIL ledr_done: got %h", LEDR);
      end
      repeat (10) @(negedge CLOCK_50);
      n_cmp++;
      if (dut.state !== 3'd6) begin n_bad++; $display("FAIL done_hold: state=%0d want 6", dut.state); end
      check_results("hold");
   endtask

   task automatic test_flags();
      int c_full, c_empty;
      do_reset();
      c_full = -1; c_empty = -1;
      for (int c = 0; c < 25000 && c_empty < 0; c++) begin
         if (c_full < 0 && dut.allFull === 1'b1) c_full = c;
         if (c_full >= 0 && c_empty < 0 && dut.emptyA === 8'hFF) c_empty = c;
         @(negedge CLOCK_50);
      end
      n_cmp++;
      if (c_full < 0 || c_empty < 0 || c_empty <= c_full) begin
         n_bad++;
         $display("FAIL flag_order: allFull@%0d emptyA@%0d want both set, empty later", c_full, c_empty);
      end
   endtask

   task automatic test_mid_reset();
      bit ok; int cyc;
      do_reset();
      wait_state(4, 200, ok, cyc);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL mac_reach: timeout state=%0d want 4", dut.state); end
      n_cmp++;
      if (dut.emptyA !== 8'h00) begin n_bad++; $display("FAIL mac_nonempty: emptyA=%h want 00", dut.emptyA); end
      repeat ($urandom_range(0, 5)) @(negedge CLOCK_50);
      KEY[0] = 1'b0;
      #1;
      n_cmp++;
      if (dut.state !== 3'd0 || dut.cout_reg !== '0 || dut.emptyA !== 8'hFF || LEDR !== 10'd0) begin
         n_bad++;
         $display("FAIL mid_reset: state=%0d cout_nz=%b emptyA=%h ledr=%h want 0/0/ff/0", dut.state, |dut.cout_reg, dut.emptyA, LEDR);
      end
      @(negedge CLOCK_50);
      KEY[0] = 1'b1;
      wait_state(6, 200, ok, cyc);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL mid_reset_done: timeout"); end
      check_results("mid");
   endtask

   task automatic test_random_aborts();
      bit ok; int cyc;
      for (int k = 0; k < 4; k++) begin
         do_reset();
         repeat ($urandom_range(1, 115)) @(negedge CLOCK_50);
         KEY[0] = 1'b0;
         #1;
         n_cmp++;
         if (dut.state !== 3'd0 || dut.cout_reg !== '0 || dut.wrenA !== 8'd0 || dut.wrenB !== 1'b0) begin
            n_bad++;
            $display("FAIL abort%0d: state=%0d cout_nz=%b want 0", k, dut.state, |dut.cout_reg);
         end
         @(negedge CLOCK_50);
         KEY[0] = 1'b1;
         wait_state(6, 200, ok, cyc);
         n_cmp++;
         if (!ok) begin n_bad++; $display("FAIL abort%0d_done: timeout", k); end
         check_results("abort");
      end
   endtask

   initial begin
      repeat (2) @(negedge CLOCK_50);
      test_reset();
      test_fillb();
      test_filla();
      test_results();
      test_flags();
      test_mid_reset();
      test_random_aborts();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
